// File: rtl/npu8_pkg.sv
// Shared NPU8 definitions: command opcodes, the command-master state encoding
// and the NPU8 register map used by the RTL and by tests.
package npu8_pkg;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WAIT  = 2'd2;
  localparam logic [1:0] OP_NOP   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_RLAT  = 3'd3,
    ST_RSP   = 3'd4,
    ST_WINT  = 3'd5
  } state_t;

  // NPU8 register map
  localparam logic [7:0] REG_STATUS     = 8'h00;
  localparam logic [7:0] REG_OP         = 8'h04;
  localparam logic [7:0] REG_START      = 8'h08;
  localparam logic [7:0] REG_SOFT_RESET = 8'h0C;
  localparam logic [7:0] REG_M0VAL      = 8'h14;
  localparam logic [7:0] REG_INT_CLR    = 8'h1C;
  localparam logic [7:0] REG_RMAX       = 8'h20;
  localparam logic [7:0] REG_RMIN       = 8'h24;

endpackage

// File: rtl/npu8_timeout_cnt.sv
// Loadable down-counter with an expiry flag; shared by read-latency and
// interrupt-wait timing in the command master.
module npu8_timeout_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  // Saturates at zero so a late dec cannot wrap into a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/npu8_cmd_master.sv
// Command-stream initiator for the NPU8 register bus: WRITE / READ / WAIT_INT /
// NOP commands in, registered bus strobes out, read data returned as responses.
module npu8_cmd_master
  import npu8_pkg::*;
#(
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 65535,
  parameter int CNT_W   = 16
) (
  input  logic        CLK,
  input  logic        RESET_X,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_OP,
  input  logic [7:0]  CMD_ADR,
  input  logic [31:0] CMD_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_DATA,
  output logic [7:0]  ADR,
  output logic        WR,
  output logic        RD,
  output logic [31:0] WDATA,
  input  logic [31:0] RDATA,
  input  logic        INT,
  output logic        BUSY,
  output logic        TIMEOUT_ERR,
  output state_t      dbg_state
);

  // Handshakes: a transfer happens on a rising CLK edge where both valid and
  // ready are high. CMD: ready depends only on state, never on CMD_VALID.
  // RSP: once RSP_VALID rises, it and RSP_DATA hold until RSP_READY is seen.

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] TO_LOAD = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam bit               TO_EN   = (TIMEOUT != 0);

  state_t           state_q, state_d;
  logic             wr_d, rd_d;
  logic [7:0]       adr_d;
  logic [31:0]      wdata_d;
  logic             rsp_valid_d;
  logic [31:0]      rsp_data_d;
  logic             err_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_expired;

  npu8_timeout_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (CLK),
    .rst_n    (RESET_X),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .expired  (cnt_expired)
  );

  always_comb begin
    state_d      = state_q;
    wr_d         = 1'b0;
    rd_d         = 1'b0;
    adr_d        = ADR;
    wdata_d      = WDATA;
    rsp_valid_d  = RSP_VALID;
    rsp_data_d   = RSP_DATA;
    err_d        = TIMEOUT_ERR;
    cnt_load     = 1'b0;
    cnt_load_val = RD_LOAD;
    cnt_dec      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          err_d = 1'b0;
          case (CMD_OP)
            OP_WRITE: begin
              state_d = ST_WRITE;
              wr_d    = 1'b1;
              adr_d   = CMD_ADR;
              wdata_d = CMD_WDATA;
            end
            OP_READ: begin
              state_d = ST_READ;
              rd_d    = 1'b1;
              adr_d   = CMD_ADR;
            end
            OP_WAIT: begin
              // Loaded here so the first WINT cycle already holds TIMEOUT-1.
              state_d      = ST_WINT;
              cnt_load     = 1'b1;
              cnt_load_val = TO_LOAD;
            end
            default: ;
          endcase
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_READ: begin
        state_d  = ST_RLAT;
        cnt_load = 1'b1;
      end
      ST_RLAT: begin
        if (cnt_expired) begin
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = RDATA;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RSP: begin
        if (RSP_READY) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      ST_WINT: begin
        // INT wins over a timeout expiring in the same cycle.
        if (INT) begin
          state_d = ST_IDLE;
        end else if (TO_EN && cnt_expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_dec = TO_EN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      state_q     <= ST_IDLE;
      WR          <= 1'b0;
      RD          <= 1'b0;
      ADR         <= '0;
      WDATA       <= '0;
      RSP_VALID   <= 1'b0;
      RSP_DATA    <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      state_q     <= state_d;
      WR          <= wr_d;
      RD          <= rd_d;
      ADR         <= adr_d;
      WDATA       <= wdata_d;
      RSP_VALID   <= rsp_valid_d;
      RSP_DATA    <= rsp_data_d;
      TIMEOUT_ERR <= err_d;
    end
  end

  assign CMD_READY = (state_q == ST_IDLE);
  assign BUSY      = !CMD_READY;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_npu8_cmd_master.sv
// Bench for npu8_cmd_master: table of single commands with hand-computed
// results, plus directed sequences for backpressure, INT wait, timeout and reset.
module tb_npu8_cmd_master;
  import npu8_pkg::*;

  localparam int RD_LAT  = 2;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 16;

  logic        clk;
  logic        RESET_X;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [1:0]  CMD_OP;
  logic [7:0]  CMD_ADR;
  logic [31:0] CMD_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_DATA;
  logic [7:0]  ADR;
  logic        WR;
  logic        RD;
  logic [31:0] WDATA;
  logic [31:0] RDATA;
  logic        INT;
  logic        BUSY;
  logic        TIMEOUT_ERR;
  state_t      dbg_state;

  logic        int_drv;
  logic        npu_int;
  int          npu_cnt;
  logic [3:0]  rd_pipe;
  logic [31:0] regs [0:255];
  bit          mem_ready;

  int total;
  int bad;
  int rsp_cnt;
  logic [31:0] exp_q[$];

  npu8_cmd_master #(
    .RD_LAT  (RD_LAT),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .CLK         (clk),
    .RESET_X     (RESET_X),
    .CMD_VALID   (CMD_VALID),
    .CMD_READY   (CMD_READY),
    .CMD_OP      (CMD_OP),
    .CMD_ADR     (CMD_ADR),
    .CMD_WDATA   (CMD_WDATA),
    .RSP_VALID   (RSP_VALID),
    .RSP_READY   (RSP_READY),
    .RSP_DATA    (RSP_DATA),
    .ADR         (ADR),
    .WR          (WR),
    .RD          (RD),
    .WDATA       (WDATA),
    .RDATA       (RDATA),
    .INT         (INT),
    .BUSY        (BUSY),
    .TIMEOUT_ERR (TIMEOUT_ERR),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- NPU bus model ----------------
  // RDATA is only meaningful in the single cycle RD_LAT after the RD strobe.
  assign RDATA = rd_pipe[RD_LAT-1] ? regs[ADR] : 32'hBAD0_0BAD;
  assign INT   = int_drv | npu_int;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) regs[i] <= 32'h0;
      mem_ready <= 1'b1;
    end else if (WR) begin
      regs[ADR] <= WDATA;
    end
    rd_pipe <= {rd_pipe[2:0], RD};
  end

  always @(posedge clk or negedge RESET_X) begin
    if (!RESET_X) begin
      npu_cnt <= 0;
      npu_int <= 1'b0;
    end else begin
      if (WR && ADR == REG_START && WDATA[0]) npu_cnt <= 3;
      else if (npu_cnt > 1) npu_cnt <= npu_cnt - 1;
      else if (npu_cnt == 1) begin
        npu_cnt <= 0;
        npu_int <= 1'b1;
      end
      if (WR && ADR == REG_INT_CLR) npu_int <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Response scoreboard: every RSP handshake must match the oldest expected read.
  always @(negedge clk) begin
    if (RESET_X && RSP_VALID && RSP_READY) begin
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got %h want none at %0t", RSP_DATA, $time);
      end else begin
        check("rsp_data", RSP_DATA, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && !CMD_READY; i++) next();
    if (!CMD_READY) begin
      total++;
      bad++;
      $display("FAIL wait_ready: got 0 want 1 at %0t", $time);
    end
  endtask

  // Drives a command so that the next rising edge is the accept cycle T.
  task automatic issue(input logic [1:0] op, input logic [7:0] adr, input logic [31:0] wd);
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_ADR   = adr;
    CMD_WDATA = wd;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  adr;
    logic [31:0] wdata;
    logic [31:0] exp_rsp;
    logic        int_lvl;
    int          exp_busy;  // cycles CMD_READY stays low after accept, -1 = unchecked
  } vec_t;

  task automatic run_vec(input vec_t v);
    int n;
    int wr_n;
    int rd_n;
    wait_ready();
    int_drv = v.int_lvl;
    issue(v.op, v.adr, v.wdata);
    if (v.op == OP_READ) exp_q.push_back(v.exp_rsp);
    next();
    CMD_VALID = 1'b0;
    n = 0;
    wr_n = 0;
    rd_n = 0;
    forever begin
      @(negedge clk);
      check("no_wr_rd_overlap", 32'(WR & RD), 32'd0);
      if (WR) begin
        wr_n++;
        check("wr_cycle", 32'(n), 32'd0);
        check("wr_adr", 32'(ADR), 32'(v.adr));
        check("wr_wdata", WDATA, v.wdata);
      end
      if (RD) begin
        rd_n++;
        check("rd_cycle", 32'(n), 32'd0);
        check("rd_adr", 32'(ADR), 32'(v.adr));
      end
      if (CMD_READY || n >= 40) break;
      n++;
      next();
    end
    if (v.exp_busy >= 0) check("busy_cycles", 32'(n), 32'(v.exp_busy));
    check("wr_count", 32'(wr_n), (v.op == OP_WRITE) ? 32'd1 : 32'd0);
    check("rd_count", 32'(rd_n), (v.op == OP_READ) ? 32'd1 : 32'd0);
    int_drv = 1'b0;
    next();
  endtask

  vec_t vecs [10];
  vec_t job  [5];
  int   rsp_before;

  initial begin
    total = 0;
    bad = 0;
    rsp_cnt = 0;
    RESET_X = 1'b0;
    CMD_VALID = 1'b0;
    CMD_OP = OP_NOP;
    CMD_ADR = 8'h00;
    CMD_WDATA = 32'h0;
    RSP_READY = 1'b1;
    int_drv = 1'b0;

    vecs[0] = '{OP_WRITE, 8'h04, 32'h0000_0001, 32'h0, 1'b0, 1};
    vecs[1] = '{OP_WRITE, 8'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1};
    vecs[2] = '{OP_READ,  8'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 2 + RD_LAT};
    vecs[3] = '{OP_WRITE, 8'h24, 32'h0000_00A5, 32'h0, 1'b0, 1};
    vecs[4] = '{OP_READ,  8'h24, 32'h0,         32'h0000_00A5, 1'b0, 2 + RD_LAT};
    vecs[5] = '{OP_NOP,   8'h55, 32'h1234_5678, 32'h0, 1'b0, 0};
    vecs[6] = '{OP_READ,  8'hFF, 32'h0,         32'h0, 1'b0, 2 + RD_LAT};
    vecs[7] = '{OP_WRITE, 8'hFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1};
    vecs[8] = '{OP_READ,  8'hFF, 32'h0,         32'hFFFF_FFFF, 1'b0, 2 + RD_LAT};
    vecs[9] = '{OP_WAIT,  8'h00, 32'h0,         32'h0, 1'b1, 1};

    job[0] = '{OP_WRITE, REG_OP,      32'h0, 32'h0, 1'b0, 1};
    job[1] = '{OP_WRITE, REG_START,   32'h1, 32'h0, 1'b0, 1};
    job[2] = '{OP_WAIT,  8'h00,       32'h0, 32'h0, 1'b0, -1};
    job[3] = '{OP_READ,  REG_RMAX,    32'h0, 32'h0, 1'b0, 2 + RD_LAT};
    job[4] = '{OP_WRITE, REG_INT_CLR, 32'h1, 32'h0, 1'b0, 1};

    // ---- reset state ----
    repeat (3) next();
    @(negedge clk);
    check("rst_cmd_ready", 32'(CMD_READY), 32'd1);
    check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("rst_rsp_data", RSP_DATA, 32'h0);
    check("rst_adr", 32'(ADR), 32'h0);
    check("rst_wdata", WDATA, 32'h0);
    check("rst_wr", 32'(WR), 32'd0);
    check("rst_rd", 32'(RD), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_timeout_err", 32'(TIMEOUT_ERR), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    next();
    RESET_X = 1'b1;
    next();

    // ---- table of single commands ----
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // ---- read with response backpressure ----
    wait_ready();
    RSP_READY = 1'b0;
    rsp_before = rsp_cnt;
    exp_q.push_back(32'hDEAD_BEEF);
    issue(OP_READ, 8'h10, 32'h0);
    next();
    CMD_VALID = 1'b0;
    @(negedge clk);
    check("bp_rd_t1", 32'(RD), 32'd1);
    for (int k = 2; k <= 3; k++) begin
      next();
      @(negedge clk);
      check("bp_rsp_early", 32'(RSP_VALID), 32'd0);
    end
    for (int k = 4; k <= 6; k++) begin
      next();
      @(negedge clk);
      check("bp_rsp_valid", 32'(RSP_VALID), 32'd1);
      check("bp_rsp_hold", RSP_DATA, 32'hDEAD_BEEF);
      check("bp_not_ready", 32'(CMD_READY), 32'd0);
    end
    next();
    RSP_READY = 1'b1;
    next();
    @(negedge clk);
    check("bp_rsp_drop", 32'(RSP_VALID), 32'd0);
    check("bp_cmd_ready", 32'(CMD_READY), 32'd1);
    check("bp_one_rsp", 32'(rsp_cnt - rsp_before), 32'd1);
    next();

    // ---- WAIT_INT, INT arrives in T+5 ----
    wait_ready();
    issue(OP_WAIT, 8'h00, 32'h0);
    next();
    CMD_VALID = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("wint_busy", 32'(BUSY), 32'd1);
      next();
    end
    int_drv = 1'b1;
    @(negedge clk);
    check("wint_int_seen_busy", 32'(CMD_READY), 32'd0);
    next();
    @(negedge clk);
    check("wint_ready_after_int", 32'(CMD_READY), 32'd1);
    check("wint_no_err", 32'(TIMEOUT_ERR), 32'd0);
    int_drv = 1'b0;
    next();

    // ---- WAIT_INT timeout, sticky flag, cleared by NOP ----
    wait_ready();
    issue(OP_WAIT, 8'h00, 32'h0);
    next();
    CMD_VALID = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("to_busy", 32'(BUSY), 32'd1);
      check("to_err_early", 32'(TIMEOUT_ERR), 32'd0);
      next();
    end
    @(negedge clk);
    check("to_err_t9", 32'(TIMEOUT_ERR), 32'd1);
    check("to_ready_t9", 32'(CMD_READY), 32'd1);
    repeat (3) next();
    @(negedge clk);
    check("to_err_sticky", 32'(TIMEOUT_ERR), 32'd1);
    next();
    issue(OP_NOP, 8'h00, 32'h0);
    next();
    CMD_VALID = 1'b0;
    @(negedge clk);
    check("nop_clears_err", 32'(TIMEOUT_ERR), 32'd0);
    check("nop_no_wr", 32'(WR), 32'd0);
    check("nop_no_rd", 32'(RD), 32'd0);
    next();

    // ---- INT and expiry in the same cycle: INT wins ----
    wait_ready();
    issue(OP_WAIT, 8'h00, 32'h0);
    next();
    CMD_VALID = 1'b0;
    repeat (7) next();
    int_drv = 1'b1;
    @(negedge clk);
    check("prio_busy_t8", 32'(BUSY), 32'd1);
    next();
    @(negedge clk);
    check("prio_no_err", 32'(TIMEOUT_ERR), 32'd0);
    check("prio_ready", 32'(CMD_READY), 32'd1);
    int_drv = 1'b0;
    next();

    // ---- reset asserted during RLAT ----
    wait_ready();
    rsp_before = rsp_cnt;
    issue(OP_READ, 8'h10, 32'h0);
    next();
    CMD_VALID = 1'b0;
    next();
    check("rlat_state", 32'(dbg_state), 32'(ST_RLAT));
    #2;
    RESET_X = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("mid_rst_rd", 32'(RD), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("mid_rst_adr", 32'(ADR), 32'h0);
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    next();
    RESET_X = 1'b1;
    repeat (8) next();
    check("no_rsp_after_rst", 32'(rsp_cnt - rsp_before), 32'd0);

    // ---- full NPU job ----
    for (int i = 0; i < 5; i++) run_vec(job[i]);
    @(negedge clk);
    check("job_no_timeout", 32'(TIMEOUT_ERR), 32'd0);

    next();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
